// File: rtl/sub_bytes_engine_if.sv
// Valid/ready bus for the SubBytes engine: block in with mode bit, substituted block out.
interface sub_bytes_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/sub_bytes_engine.sv
// AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per cycle,
// with valid/ready handshakes on both sides.
module sub_bytes_engine #(
  parameter int unsigned LANES = 16
) (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_engine_if.slave bus,
  output logic              busy
);

  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Byte x of each table sits at bits [2047-8x -: 8].
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    int base;
    base = 2047 - 8 * int'(x);
    return inv ? INV_SBOX[base -: 8] : FWD_SBOX[base -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] beat;
  logic [127:0]  work;
  logic [127:0]  work_sub;
  logic          mode;
  logic          out_valid_q;
  logic          busy_q;
  logic          take;

  // out_valid_q marks DONE and busy_q marks BUSY, so in_ready never sees in_valid.
  assign bus.in_ready  = out_valid_q ? bus.out_ready : ~busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = work;
  assign busy          = busy_q;
  assign take          = bus.in_valid & bus.in_ready;

  always_comb begin
    work_sub = work;
    for (int unsigned i = 0; i < LANES; i++) begin
      work_sub[(32'(beat) * LANES + i) * 8 +: 8] =
        sub_byte(work[(32'(beat) * LANES + i) * 8 +: 8], mode);
    end
  end

  // A load can only occur from IDLE or from DONE with out_ready high, so it is
  // handled once ahead of the per-state cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      work        <= '0;
      mode        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (take) begin
      work        <= bus.in_state;
      mode        <= bus.in_inv;
      beat        <= '0;
      state       <= BUSY;
      busy_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          work <= work_sub;
          if (beat == LAST_BEAT) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: one instance per legal LANES value
// (index d -> LANES = 16 >> d, BEATS = 1 << d).
module tb_sub_bytes_engine;

  localparam logic [127:0] FIPS_IN = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_SB = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] MIX_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] MIX_SB  = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         in_valid  [5];
  logic         in_inv    [5];
  logic         out_ready [5];
  logic [127:0] in_state  [5];
  logic         in_ready  [5];
  logic         out_valid [5];
  logic         busy      [5];
  logic [127:0] out_state [5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_state  = in_state[g];
    assign bus.in_inv    = in_inv[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_state[g]  = bus.out_state;

    sub_bytes_engine #(.LANES(16 >> g)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy[g])
    );
  end

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with the DUT back in IDLE.
  task automatic run_block(input int d, input logic [127:0] st, input logic inv,
                           output logic [127:0] res, output int lat, output int bcnt);
    int guard;
    in_valid[d]  = 1'b1;
    in_state[d]  = st;
    in_inv[d]    = inv;
    out_ready[d] = 1'b1;
    guard = 0;
    #1;
    while (!in_ready[d] && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_state[d] = {$urandom, $urandom, $urandom, $urandom};
    in_inv[d]   = ~inv;
    lat  = 0;
    bcnt = 0;
    while (!out_valid[d] && lat < 40) begin
      if (busy[d]) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = out_state[d];
    @(negedge clk);
  endtask

  typedef struct {
    int           d;
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [127:0] res, r2, pat;
    logic [7:0]   xb;
    int           lat, bcnt, g;

    vecs[0]  = '{0, FIPS_IN,         1'b0, FIPS_SB};
    vecs[1]  = '{2, FIPS_SB,         1'b1, FIPS_IN};
    vecs[2]  = '{4, '0,              1'b0, {16{8'h63}}};
    vecs[3]  = '{4, '0,              1'b1, {16{8'h52}}};
    vecs[4]  = '{1, {16{8'h53}},     1'b0, {16{8'hed}}};
    vecs[5]  = '{3, {16{8'h63}},     1'b1, '0};
    vecs[6]  = '{0, {16{8'hed}},     1'b1, {16{8'h53}}};
    vecs[7]  = '{1, FIPS_IN,         1'b0, FIPS_SB};
    vecs[8]  = '{3, FIPS_IN,         1'b0, FIPS_SB};
    vecs[9]  = '{4, FIPS_SB,         1'b1, FIPS_IN};
    vecs[10] = '{2, MIX_IN,          1'b0, MIX_SB};

    for (int d = 0; d < 5; d++) begin
      in_valid[d]  = 1'b0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b0;
      in_state[d]  = '0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      check_bit($sformatf("rst in_ready d%0d", d), in_ready[d], 1'b1);
      check_bit($sformatf("rst out_valid d%0d", d), out_valid[d], 1'b0);
      check_bit($sformatf("rst busy d%0d", d), busy[d], 1'b0);
      check_vec($sformatf("rst out_state d%0d", d), out_state[d], '0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_block(vecs[i].d, vecs[i].st, vecs[i].inv, res, lat, bcnt);
      check_vec($sformatf("vec%0d result", i), res, vecs[i].exp);
      check_int($sformatf("vec%0d latency", i), lat, 1 << vecs[i].d);
      check_int($sformatf("vec%0d busy cycles", i), bcnt, 1 << vecs[i].d);
    end

    // Back-pressure on LANES=2 with input churn, then a same-cycle hand-off.
    in_valid[3] = 1'b1; in_state[3] = FIPS_IN; in_inv[3] = 1'b0; out_ready[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[3] = 1'b0;
    g = 0;
    while (!out_valid[3] && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_int("bp first latency", g, 8);
    for (int i = 0; i < 10; i++) begin
      in_inv[3]   = (i % 2 == 0);
      in_state[3] = {$urandom, $urandom, $urandom, $urandom};
      in_valid[3] = 1'b1;
      #1;
      check_bit($sformatf("bp in_ready c%0d", i), in_ready[3], 1'b0);
      check_bit($sformatf("bp out_valid c%0d", i), out_valid[3], 1'b1);
      check_vec($sformatf("bp out_state c%0d", i), out_state[3], FIPS_SB);
      @(negedge clk);
    end
    in_state[3] = '0; in_inv[3] = 1'b1; in_valid[3] = 1'b1; out_ready[3] = 1'b1;
    #1;
    check_bit("bp handoff in_ready", in_ready[3], 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid[3] = 1'b0;
    check_bit("bp handoff out_valid drop", out_valid[3], 1'b0);
    check_bit("bp handoff busy", busy[3], 1'b1);
    g = 0;
    while (!out_valid[3] && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_int("bp second latency", g, 8);
    check_vec("bp second result", out_state[3], {16{8'h52}});
    @(negedge clk);
    check_bit("bp back to idle", in_ready[3], 1'b1);

    // Reset during beat 7 of a LANES=1 block.
    in_valid[4] = 1'b1; in_state[4] = {16{8'h11}}; in_inv[4] = 1'b0; out_ready[4] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[4] = 1'b0;
    repeat (7) @(negedge clk);
    check_bit("midbusy busy before rst", busy[4], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("midbusy in_ready", in_ready[4], 1'b1);
    check_bit("midbusy out_valid", out_valid[4], 1'b0);
    check_bit("midbusy busy", busy[4], 1'b0);
    check_vec("midbusy out_state", out_state[4], '0);
    @(negedge clk);
    rst = 1'b0;
    run_block(4, {16{8'h53}}, 1'b0, res, lat, bcnt);
    check_vec("after rst result", res, {16{8'hed}});
    check_int("after rst latency", lat, 16);

    // Reset while a LANES=16 result is held in DONE.
    in_valid[0] = 1'b1; in_state[0] = FIPS_IN; in_inv[0] = 1'b0; out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    g = 0;
    while (!out_valid[0] && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_bit("middone out_valid before rst", out_valid[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check_bit("middone out_valid", out_valid[0], 1'b0);
    check_bit("middone in_ready", in_ready[0], 1'b1);
    check_vec("middone out_state", out_state[0], '0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, FIPS_IN, 1'b0, res, lat, bcnt);
    check_vec("after middone result", res, FIPS_SB);

    // Forward then inverse must return every byte value, on every lane width.
    for (int d = 0; d < 5; d++) begin
      for (int x = 0; x < 256; x++) begin
        xb  = 8'(x);
        pat = {16{xb}};
        run_block(d, pat, 1'b0, res, lat, bcnt);
        run_block(d, res, 1'b1, r2, lat, bcnt);
        check_vec($sformatf("roundtrip d%0d x%02h", d, xb), r2, pat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
